// File: rtl/dll_lock_monitor.sv
// Frequency-lock monitor: counts clock cycles per synchronized osc period, compares with div, reports lock/loss.
// Latency: rise acted on 3 edges after osc rises; count_valid/period_count/locked/lost update the cycle after capture.
// No backpressure: measurements are one-cycle pulses, status outputs are level signals.
module dll_lock_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [4:0]       div,
    input  logic             clr_lost,
    output logic             locked,
    output logic             lost,
    output logic             count_valid,
    output logic [CNT_W-1:0] period_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W:0]   TOL_V    = TOL[CNT_W:0];
    localparam logic [3:0]       LOCK_V   = 4'(LOCK_COUNT);

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               hist_q, hist_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         good_q, good_d;
    logic [CNT_W-1:0]   period_count_q, period_count_d;
    logic               count_valid_q, count_valid_d;
    logic               locked_q, locked_d;
    logic               lost_q, lost_d;

    logic               rise;
    logic               window_end;
    logic [CNT_W-1:0]   meas;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]     abs_diff;
    logic               pass;
    logic [3:0]         good_inc;
    logic               lost_set;

    // Window measurement and tolerance test on the value about to be captured
    always_comb begin
        sync1_d    = osc;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        rise       = sync2_q & ~hist_q;
        window_end = rise | (cnt_q == CNT_LAST);
        // A timeout captures the saturated value; a rise captures the running count plus this cycle
        meas       = rise ? cnt_q + 1'b1 : CNT_MAX;
        diff       = $signed({1'b0, meas}) - $signed({{(CNT_W-4){1'b0}}, div});
        abs_diff   = diff[CNT_W] ? -diff : diff;
        // A timeout window never passes, nor does an unprogrammed ratio
        pass       = rise && (div != 5'd0) && (abs_diff <= TOL_V);
        good_inc   = (good_q == LOCK_V) ? good_q : good_q + 4'd1;
    end

    // Next-state, counters and status outputs
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_d         = good_q;
        period_count_d = period_count_q;
        count_valid_d  = 1'b0;
        lost_set       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                good_d = 4'd0;
                if (enable) begin
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                // First edge only aligns the counter; its period is unknown
                cnt_d = '0;
                if (rise) begin
                    state_d = TRACK;
                end
            end
            TRACK, LOCKED: begin
                if (window_end) begin
                    cnt_d          = '0;
                    period_count_d = meas;
                    count_valid_d  = 1'b1;
                    good_d         = pass ? good_inc : 4'd0;
                    if (state_q == TRACK) begin
                        if (pass && (good_inc == LOCK_V)) begin
                            state_d = LOCKED;
                        end
                    end else if (!pass) begin
                        state_d  = TRACK;
                        lost_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disabling overrides everything except the held measurement and sticky lost
        if (!enable) begin
            state_d       = IDLE;
            cnt_d         = '0;
            good_d        = 4'd0;
            count_valid_d = 1'b0;
            lost_set      = 1'b0;
        end

        locked_d = (state_d == LOCKED);
        lost_d   = lost_set | (lost_q & ~clr_lost);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            hist_q         <= 1'b0;
            cnt_q          <= '0;
            good_q         <= 4'd0;
            period_count_q <= '0;
            count_valid_q  <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            hist_q         <= hist_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            period_count_q <= period_count_d;
            count_valid_q  <= count_valid_d;
            locked_q       <= locked_d;
            lost_q         <= lost_d;
        end
    end

    assign locked       = locked_q;
    assign lost         = lost_q;
    assign count_valid  = count_valid_q;
    assign period_count = period_count_q;

endmodule

// File: tb/tb_dll_lock_monitor.sv
// Randomized bench for dll_lock_monitor against a timestamp-based reference model.
// Latency: model predicts outputs per clock edge; compared 1 time unit after each rising edge.
// No backpressure: inputs are driven freely every cycle.
module tb_dll_lock_monitor;

    logic       clock = 1'b0;
    logic       resetb;
    logic       enable;
    logic       osc;
    logic [4:0] div;
    logic       clr_lost;
    logic       locked;
    logic       lost;
    logic       count_valid;
    logic [7:0] period_count;

    dll_lock_monitor #(
        .CNT_W(8),
        .LOCK_COUNT(4),
        .TOL(1)
    ) dut (
        .clock(clock),
        .resetb(resetb),
        .enable(enable),
        .osc(osc),
        .div(div),
        .clr_lost(clr_lost),
        .locked(locked),
        .lost(lost),
        .count_valid(count_valid),
        .period_count(period_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int n        = 0;          // index of the most recent rising clock edge
    bit osc_at[0:65535];       // osc level sampled at each edge
    int last_reset = -1;       // edge at which reset was last sampled
    bit clr_rand = 1'b0;

    // Reference model: mode 0 = off, 1 = waiting for first edge, 2 = measuring
    int m_mode   = 0;
    int m_last   = 0;          // edge at which the current window started
    int m_good   = 0;          // consecutive passing windows, saturating at 4
    bit m_locked = 1'b0;
    bit m_lost   = 1'b0;
    bit m_cv     = 1'b0;
    int m_pc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
        end
    endtask

    // osc level as the synchronizer saw it: anything sampled at or before reset reads low
    function automatic bit osc_eff(input int k);
        if (k < 0 || k <= last_reset) return 1'b0;
        return osc_at[k];
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        bit rise_m;
        bit pass;
        bit set_lost;
        int el;
        int err;
        rise_m   = (n >= 3) && osc_eff(n - 2) && !osc_eff(n - 3);
        set_lost = 1'b0;
        if (!resetb) begin
            m_mode = 0; m_good = 0; m_locked = 0; m_lost = 0; m_cv = 0; m_pc = 0;
            last_reset = n;
        end else begin
            m_cv = 1'b0;
            if (!enable) begin
                m_mode = 0; m_good = 0; m_locked = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (rise_m) begin
                    m_mode = 2;
                    m_last = n;
                end
            end else begin
                el = n - m_last;
                if (rise_m || el >= 255) begin
                    m_cv  = 1'b1;
                    m_pc  = (el > 255) ? 255 : el;
                    err   = m_pc - int'(div);
                    if (err < 0) err = -err;
                    pass  = rise_m && (div != 0) && (err <= 1);
                    m_last = n;
                    m_good = pass ? ((m_good < 4) ? m_good + 1 : 4) : 0;
                    if (m_locked && !pass) begin
                        m_locked = 1'b0;
                        set_lost = 1'b1;
                    end else if (!m_locked && m_good == 4) begin
                        m_locked = 1'b1;
                    end
                end
            end
            m_lost = set_lost | (m_lost & !clr_lost);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        n++;
        osc_at[n] = osc;
        model_step();
        #1;
        check("locked", locked, m_locked);
        check("lost", lost, m_lost);
        check("count_valid", count_valid, m_cv);
        check("period_count", period_count, m_pc);
        if (clr_rand) clr_lost = ($urandom_range(0, 15) == 0);
    endtask

    task automatic osc_run(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            osc = 1'b1;
            repeat (hi) tick();
            osc = 1'b0;
            repeat (lo) tick();
        end
    endtask

    initial begin
        int per;
        int hi;
        int guard;
        resetb = 1'b0; enable = 1'b0; osc = 1'b0; div = 5'd8; clr_lost = 1'b0;
        repeat (3) tick();
        check("reset_locked", locked, 0);
        check("reset_pc", period_count, 0);
        resetb = 1'b1;
        repeat (2) tick();

        // Nominal ratio: lock after four good windows following the discarded edge
        enable = 1'b1;
        osc_run(4, 4, 8);
        check("lock_div8", locked, 1);
        check("pc_div8", period_count, 8);

        // Within tolerance keeps lock; a period of 10 drops it
        osc_run(5, 4, 1); osc_run(4, 3, 1); osc_run(5, 4, 1);
        check("lock_tol", locked, 1);
        osc_run(5, 5, 1);
        osc_run(4, 4, 6);
        check("lost_after_10", lost, 1);

        // Stopped reference: repeated timeouts
        osc = 1'b0;
        repeat (600) tick();
        check("timeout_unlocked", locked, 0);
        check("timeout_pc", period_count, 255);

        // Clear lost, relock, then clear in the same cycle as a new loss
        clr_lost = 1'b1; tick(); clr_lost = 1'b0; tick();
        check("lost_cleared", lost, 0);
        osc_run(4, 4, 8);
        osc = 1'b0;
        guard = 0;
        while ((n - m_last) != 254 && guard < 400) begin
            tick();
            guard++;
        end
        check("timeout_align", (n - m_last), 254);
        clr_lost = 1'b1; tick(); clr_lost = 1'b0;
        check("lost_set_wins", lost, 1);

        // Unprogrammed ratio never locks
        div = 5'd0;
        osc_run(3, 5, 10);
        check("div0_nolock", locked, 0);

        // Reset while locked
        div = 5'd8;
        osc_run(4, 4, 8);
        resetb = 1'b0; tick(); resetb = 1'b1;
        check("rst_lost", lost, 0);
        check("rst_pc", period_count, 0);
        osc_run(4, 4, 6);

        // Disable while locked: lost retained, pc held
        osc_run(5, 5, 1); osc_run(4, 4, 6);
        enable = 1'b0; tick(); tick(); enable = 1'b1;
        check("dis_lost_kept", lost, 1);
        check("dis_unlocked", locked, 0);
        osc_run(4, 4, 6);

        // Randomized phase
        clr_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            div = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(6, 20));
            for (int s = 0; s < 4; s++) begin
                case ($urandom_range(0, 9))
                    0: per = $urandom_range(2, 40);
                    1: begin osc = 1'b0; repeat ($urandom_range(250, 300)) tick(); per = 0; end
                    2: begin enable = 1'b0; repeat ($urandom_range(1, 4)) tick(); enable = 1'b1; per = 0; end
                    3: begin resetb = 1'b0; tick(); resetb = 1'b1; per = 0; end
                    default: per = int'(div) + $urandom_range(0, 4) - 2;
                endcase
                if (per >= 2) begin
                    hi = $urandom_range(1, per - 1);
                    osc_run(hi, per - hi, $urandom_range(1, 10));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
